axi_sram_slv: RTL and testbench
===============================

# axi_sram_slv

AXI4-Lite responder modelling on-chip SRAM; terminates the single master port driven by the IFU/LSU arbiter (`mst_*` side). Services one read and one write transaction concurrently, each through its own state machine, with programmable response latency. Out-of-range addresses get DECERR. Used as the memory endpoint in NPC simulation and as the slave model for arbiter and bus verification.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width = `DATA_W/8`
- `BASE_ADDR`, 32'h8000_0000, first decoded byte address
- `DEPTH`, 1024, memory size in `DATA_W` words; power of two
- `RD_LAT`, 1, extra cycles between AR handshake and R valid (0..15)
- `WR_LAT`, 1, extra cycles between AW+W capture and B valid (0..15)

Ports:
- `clk_i` in 1: clock, all logic on rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `ar_valid_i` in 1 / `ar_addr_i` in ADDR_W / `ar_ready_o` out 1: read address
- `r_valid_o` out 1 / `r_data_o` out DATA_W / `r_resp_o` out axi_resp_t / `r_ready_i` in 1: read data
- `aw_valid_i` in 1 / `aw_addr_i` in ADDR_W / `aw_ready_o` out 1: write address
- `w_valid_i` in 1 / `w_data_i` in DATA_W / `w_strb_i` in DATA_W/8 / `w_ready_o` out 1: write data
- `b_valid_o` out 1 / `b_resp_o` out axi_resp_t / `b_ready_i` in 1: write response

## Operation
- Decode: hit iff `BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8`; word index = `(addr - BASE_ADDR) >> log2(DATA_W/8)`; low byte-offset bits ignored.
- Read FSM: R_IDLE -> (AR hs) R_WAIT -> (counter == 0) R_RESP -> (R hs) R_IDLE.
  - AR hs latches address, loads counter with delay D; counter decrements in R_WAIT.
  - Memory sampled on R_WAIT->R_RESP; `r_data_o`/`r_resp_o` registered, held stable until R hs.
  - Miss: `r_resp_o`=DECERR, `r_data_o`=0.
- Write FSM: W_IDLE -> (AW and W both captured) W_WAIT -> (counter == 0) W_RESP -> (B hs) W_IDLE.
  - AW and W accepted independently in W_IDLE; each ready drops after its capture; order free, same-cycle allowed.
  - Commit on W_WAIT->W_RESP: byte lanes with strobe 1 written; hit -> OKAY, miss -> DECERR with no write.
- One outstanding read, one outstanding write; read and write FSMs fully independent.
- Same-cycle commit and read sample at same word: read returns pre-write data.
- Memory contents not cleared by reset.

## Timing
- Reset values: `ar_ready_o`=1, `aw_ready_o`=1, `w_ready_o`=1, `r_valid_o`=0, `b_valid_o`=0, `r_data_o`=0, `r_resp_o`=OKAY, `b_resp_o`=OKAY; FSMs in IDLE.
- All outputs registered; no combinational path input->output.
- AR hs in cycle N -> `r_valid_o` high from cycle N+1+D; D=`RD_LAT`.
- Last of AW/W captured in cycle N -> `b_valid_o` high from cycle N+1+D; D=`WR_LAT`.
- `ar_ready_o` returns 1 the cycle after R hs; `aw_ready_o`/`w_ready_o` the cycle after B hs. Back-to-back reads: minimum 2+D cycles per transaction.
- Valid never deasserted before its handshake; `r_ready_i`/`b_ready_i` held low indefinitely keeps response stable.
- Reset mid-transaction: outstanding transactions dropped, outputs to reset values immediately; a pending write not yet committed is lost.

## Configuration
- `AXI_SRAM_RAND_DELAY_EN` defined: 8-bit LFSR (taps 8,6,5,4), seed 8'hA5 at reset, advances every cycle; D = LAT + `lfsr[2:0]` (sampled at handshake), read and write use independent bit slices (`[2:0]`, `[5:3]`).
- Undefined: D = `RD_LAT`/`WR_LAT` exactly, LFSR not instantiated.

## Structure
- `axi_pkg`: `axi_resp_t` (2 bits) with OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11; read/write FSM state enums.
- Sub-module `axi_sram_lfsr` (seeded LFSR), instantiated only under the macro.

## Test plan
- Write 0x8000_0010 data 0xDEADBEEF strb 4'hF, then read same -> B OKAY, R data 0xDEADBEEF OKAY; R valid at AR hs cycle +1+`RD_LAT`.
- Write strb 4'b0101 data 0x11223344 over 0xDEADBEEF -> read returns 0xDE22BE44.
- W presented 3 cycles before AW -> `w_ready_o` low after capture, B valid `WR_LAT`+1 cycles after AW hs.
- Read 0x0000_0000 and write 0x9000_0000 -> DECERR, data 0, memory unchanged.
- `r_ready_i` held low 10 cycles -> `r_valid_o`/`r_data_o` stable, `ar_ready_o` stays 0 until hs.
- `rst_i` pulsed during R_WAIT -> `r_valid_o` never asserts, `ar_ready_o`=1 immediately; previously written data still readable.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response encoding, SRAM responder FSM states and the LFSR
// step function used by the optional randomised-latency build.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_RESP = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_WAIT = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  // Wide enough for the largest latency (15) plus the random extra (7).
  localparam int unsigned DLY_W     = 5;
  localparam int unsigned LFSR_W    = 8;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  // Fibonacci step, taps 8,6,5,4.
  function automatic logic [LFSR_W-1:0] lfsr_next_f(input logic [LFSR_W-1:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/axi_sram_lfsr.sv
// Free-running seeded 8-bit LFSR supplying random latency jitter to the SRAM
// responder; it advances on every clock and reloads its seed on reset.
module axi_sram_lfsr
  import axi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_r;

  // Shift register, reseeded by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next_f(lfsr_r);
    end
  end

  assign lfsr_o = lfsr_r;

endmodule

// File: rtl/axi_sram_slv.sv
// AXI4-Lite SRAM responder with independent read and write FSMs and
// programmable response latency. Define AXI_SRAM_RAND_DELAY_EN to add LFSR jitter.
module axi_sram_slv
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       RD_LAT    = 1,
  parameter int unsigned       WR_LAT    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ar_valid_i,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  output logic                ar_ready_o,
  output logic                r_valid_o,
  output logic [DATA_W-1:0]   r_data_o,
  output axi_resp_t           r_resp_o,
  input  logic                r_ready_i,
  input  logic                aw_valid_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  output logic                aw_ready_o,
  input  logic                w_valid_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  output logic                w_ready_o,
  output logic                b_valid_o,
  output axi_resp_t           b_resp_o,
  input  logic                b_ready_i
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0] SPAN_C = AW1'(DEPTH) << OFF_W;

  function automatic logic addr_hit_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN_C);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx_f(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [DLY_W-1:0] rd_dly_s;
  logic [DLY_W-1:0] wr_dly_s;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [LFSR_W-1:0] lfsr_s;

  axi_sram_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lfsr_o (lfsr_s)
  );

  assign rd_dly_s = DLY_W'(RD_LAT) + {2'b00, lfsr_s[2:0]};
  assign wr_dly_s = DLY_W'(WR_LAT) + {2'b00, lfsr_s[5:3]};
`else
  assign rd_dly_s = DLY_W'(RD_LAT);
  assign wr_dly_s = DLY_W'(WR_LAT);
`endif

  // ---------------- read channel ----------------
  rd_state_e         r_state_r, r_nxt_s;
  logic [DLY_W-1:0]  r_cnt_r, r_cnt_nxt_s;
  logic              r_sample_s;
  logic [ADDR_W-1:0] ar_addr_r;
  logic [ADDR_W-1:0] rd_addr_eff_s;
  logic              rd_hit_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              ar_hs_s;
  logic              ar_ready_r, r_valid_r;
  logic [DATA_W-1:0] r_data_r;
  axi_resp_t         r_resp_r;

  assign ar_hs_s       = ar_valid_i & ar_ready_r;
  // With zero latency the sample happens in the handshake cycle itself.
  assign rd_addr_eff_s = ar_hs_s ? ar_addr_i : ar_addr_r;
  assign rd_hit_s      = addr_hit_f(rd_addr_eff_s);
  assign rd_idx_s      = addr_idx_f(rd_addr_eff_s);

  // Read next-state, countdown and sample strobe.
  always_comb begin
    r_nxt_s     = r_state_r;
    r_cnt_nxt_s = r_cnt_r;
    r_sample_s  = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          if (rd_dly_s == DLY_W'(0)) begin
            r_nxt_s    = R_RESP;
            r_sample_s = 1'b1;
          end else begin
            r_nxt_s     = R_WAIT;
            r_cnt_nxt_s = rd_dly_s - DLY_W'(1);
          end
        end else begin
          r_nxt_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_cnt_r == DLY_W'(0)) begin
          r_nxt_s    = R_RESP;
          r_sample_s = 1'b1;
        end else begin
          r_cnt_nxt_s = r_cnt_r - DLY_W'(1);
        end
      end
      R_RESP: begin
        if (r_ready_i) begin
          r_nxt_s = R_IDLE;
        end else begin
          r_nxt_s = R_RESP;
        end
      end
      default: begin
        r_nxt_s = R_IDLE;
      end
    endcase
  end

  // Read state register and registered R/AR outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_r  <= R_IDLE;
      r_cnt_r    <= DLY_W'(0);
      ar_addr_r  <= {ADDR_W{1'b0}};
      ar_ready_r <= 1'b1;
      r_valid_r  <= 1'b0;
      r_data_r   <= {DATA_W{1'b0}};
      r_resp_r   <= OKAY;
    end else begin
      r_state_r  <= r_nxt_s;
      r_cnt_r    <= r_cnt_nxt_s;
      ar_ready_r <= (r_nxt_s == R_IDLE);
      r_valid_r  <= (r_nxt_s == R_RESP);
      if (ar_hs_s) begin
        ar_addr_r <= ar_addr_i;
      end
      if (r_sample_s) begin
        r_data_r <= rd_hit_s ? mem_r[rd_idx_s] : {DATA_W{1'b0}};
        r_resp_r <= rd_hit_s ? OKAY : DECERR;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e          w_state_r, w_nxt_s;
  logic [DLY_W-1:0]   w_cnt_r, w_cnt_nxt_s;
  logic               aw_got_r, aw_got_nxt_s;
  logic               w_got_r, w_got_nxt_s;
  logic               w_commit_s;
  logic [ADDR_W-1:0]  aw_addr_r;
  logic [DATA_W-1:0]  w_data_r;
  logic [BYTES-1:0]   w_strb_r;
  logic [ADDR_W-1:0]  wr_addr_eff_s;
  logic [DATA_W-1:0]  wr_data_eff_s;
  logic [BYTES-1:0]   wr_strb_eff_s;
  logic               wr_hit_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic               aw_hs_s, w_hs_s;
  logic               aw_ready_r, w_ready_r, b_valid_r;
  axi_resp_t          b_resp_r;

  assign aw_hs_s       = aw_valid_i & aw_ready_r;
  assign w_hs_s        = w_valid_i & w_ready_r;
  assign wr_addr_eff_s = aw_hs_s ? aw_addr_i : aw_addr_r;
  assign wr_data_eff_s = w_hs_s ? w_data_i : w_data_r;
  assign wr_strb_eff_s = w_hs_s ? w_strb_i : w_strb_r;
  assign wr_hit_s      = addr_hit_f(wr_addr_eff_s);
  assign wr_idx_s      = addr_idx_f(wr_addr_eff_s);

  // Write next-state, capture flags, countdown and commit strobe.
  always_comb begin
    w_nxt_s      = w_state_r;
    w_cnt_nxt_s  = w_cnt_r;
    aw_got_nxt_s = aw_got_r;
    w_got_nxt_s  = w_got_r;
    w_commit_s   = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        aw_got_nxt_s = aw_got_r | aw_hs_s;
        w_got_nxt_s  = w_got_r | w_hs_s;
        if (aw_got_nxt_s && w_got_nxt_s) begin
          aw_got_nxt_s = 1'b0;
          w_got_nxt_s  = 1'b0;
          if (wr_dly_s == DLY_W'(0)) begin
            w_nxt_s    = W_RESP;
            w_commit_s = 1'b1;
          end else begin
            w_nxt_s     = W_WAIT;
            w_cnt_nxt_s = wr_dly_s - DLY_W'(1);
          end
        end else begin
          w_nxt_s = W_IDLE;
        end
      end
      W_WAIT: begin
        if (w_cnt_r == DLY_W'(0)) begin
          w_nxt_s    = W_RESP;
          w_commit_s = 1'b1;
        end else begin
          w_cnt_nxt_s = w_cnt_r - DLY_W'(1);
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          w_nxt_s = W_IDLE;
        end else begin
          w_nxt_s = W_RESP;
        end
      end
      default: begin
        w_nxt_s = W_IDLE;
      end
    endcase
  end

  // Write state register and registered AW/W/B outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_r  <= W_IDLE;
      w_cnt_r    <= DLY_W'(0);
      aw_got_r   <= 1'b0;
      w_got_r    <= 1'b0;
      aw_addr_r  <= {ADDR_W{1'b0}};
      w_data_r   <= {DATA_W{1'b0}};
      w_strb_r   <= {BYTES{1'b0}};
      aw_ready_r <= 1'b1;
      w_ready_r  <= 1'b1;
      b_valid_r  <= 1'b0;
      b_resp_r   <= OKAY;
    end else begin
      w_state_r  <= w_nxt_s;
      w_cnt_r    <= w_cnt_nxt_s;
      aw_got_r   <= aw_got_nxt_s;
      w_got_r    <= w_got_nxt_s;
      aw_ready_r <= (w_nxt_s == W_IDLE) && !aw_got_nxt_s;
      w_ready_r  <= (w_nxt_s == W_IDLE) && !w_got_nxt_s;
      b_valid_r  <= (w_nxt_s == W_RESP);
      if (aw_hs_s) begin
        aw_addr_r <= aw_addr_i;
      end
      if (w_hs_s) begin
        w_data_r <= w_data_i;
        w_strb_r <= w_strb_i;
      end
      if (w_commit_s) begin
        b_resp_r <= wr_hit_s ? OKAY : DECERR;
      end
    end
  end

  // Byte-lane commit; storage is intentionally left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (w_commit_s && wr_hit_s) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (wr_strb_eff_s[b]) begin
          mem_r[wr_idx_s][8*b +: 8] <= wr_data_eff_s[8*b +: 8];
        end
      end
    end
  end

  assign ar_ready_o = ar_ready_r;
  assign r_valid_o  = r_valid_r;
  assign r_data_o   = r_data_r;
  assign r_resp_o   = r_resp_r;
  assign aw_ready_o = aw_ready_r;
  assign w_ready_o  = w_ready_r;
  assign b_valid_o  = b_valid_r;
  assign b_resp_o   = b_resp_r;

endmodule

// File: tb/tb_axi_sram_slv.sv
// Scoreboard bench for axi_sram_slv: tasks push expected R/B responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_axi_sram_slv;
  import axi_pkg::*;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned WR_LAT = 1;
  localparam int          TMO    = 50;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ar_valid_i = 1'b0;
  logic [31:0] ar_addr_i = 32'h0;
  logic        ar_ready_o;
  logic        r_valid_o;
  logic [31:0] r_data_o;
  axi_resp_t   r_resp_o;
  logic        r_ready_i = 1'b1;
  logic        aw_valid_i = 1'b0;
  logic [31:0] aw_addr_i = 32'h0;
  logic        aw_ready_o;
  logic        w_valid_i = 1'b0;
  logic [31:0] w_data_i = 32'h0;
  logic [3:0]  w_strb_i = 4'h0;
  logic        w_ready_o;
  logic        b_valid_o;
  axi_resp_t   b_resp_o;
  logic        b_ready_i = 1'b1;

  axi_sram_slv #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h8000_0000),
    .DEPTH(1024), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_addr_i(ar_addr_i), .ar_ready_o(ar_ready_o),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_ready_i(r_ready_i),
    .aw_valid_i(aw_valid_i), .aw_addr_i(aw_addr_i), .aw_ready_o(aw_ready_o),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_ready_o(w_ready_o),
    .b_valid_o(b_valid_o), .b_resp_o(b_resp_o), .b_ready_i(b_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  r_exp_t     r_q[$];
  logic [1:0] b_q[$];
  r_exp_t     r_e;
  logic [1:0] b_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles, got 0 expected 1", name, TMO);
  endtask

  // Response monitor: compares every R/B handshake against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && r_valid_o && r_ready_i) begin
      if (r_q.size() == 0) begin
        check("r_unexpected", 64'd1, 64'd0);
      end else begin
        r_e = r_q.pop_front();
        check("r_data", r_data_o, r_e.data);
        check("r_resp", r_resp_o, r_e.resp);
      end
    end
    if (!rst_i && b_valid_o && b_ready_i) begin
      if (b_q.size() == 0) begin
        check("b_unexpected", 64'd1, 64'd0);
      end else begin
        b_e = b_q.pop_front();
        check("b_resp", b_resp_o, b_e);
      end
    end
  end

  task automatic read_tx(input logic [31:0] addr, input logic [31:0] exp_data, input axi_resp_t exp_resp);
    int t;
    int unsigned hs_cyc;
    r_q.push_back({exp_resp, exp_data});
    @(posedge clk_i); #1;
    ar_valid_i = 1'b1;
    ar_addr_i  = addr;
    @(negedge clk_i);
    t = 0;
    while (!ar_ready_o && t < TMO) begin @(negedge clk_i); t++; end
    if (t >= TMO) timeout("ar_ready");
    hs_cyc = cyc;
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    @(negedge clk_i);
    t = 0;
    while (!r_valid_o && t < TMO) begin @(negedge clk_i); t++; end
    if (t >= TMO) timeout("r_valid");
    check("r_latency", 64'(cyc - hs_cyc), 64'(1 + RD_LAT));
    t = 0;
    while (!r_ready_i && t < TMO) begin @(negedge clk_i); t++; end
    @(posedge clk_i);
    @(negedge clk_i);
    check("ar_ready_after_r", ar_ready_o, 1);
  endtask

  task automatic write_tx(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input axi_resp_t exp_resp, input int lead);
    int t;
    int unsigned last_cyc;
    b_q.push_back(exp_resp);
    @(posedge clk_i); #1;
    w_valid_i = 1'b1;
    w_data_i  = data;
    w_strb_i  = strb;
    if (lead > 0) begin
      @(negedge clk_i);
      check("w_ready_idle", w_ready_o, 1);
      @(posedge clk_i); #1;
      w_valid_i = 1'b0;
      w_data_i  = 32'h0;
      w_strb_i  = 4'h0;
      for (int i = 0; i < lead - 1; i++) begin
        @(negedge clk_i);
        check("w_ready_captured", w_ready_o, 0);
        check("b_valid_early", b_valid_o, 0);
        @(posedge clk_i); #1;
      end
    end
    aw_valid_i = 1'b1;
    aw_addr_i  = addr;
    @(negedge clk_i);
    t = 0;
    while (!(aw_ready_o && (lead > 0 || w_ready_o)) && t < TMO) begin @(negedge clk_i); t++; end
    if (t >= TMO) timeout("aw_w_ready");
    last_cyc = cyc;
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    @(negedge clk_i);
    check("aw_ready_busy", aw_ready_o, 0);
    t = 0;
    while (!b_valid_o && t < TMO) begin @(negedge clk_i); t++; end
    if (t >= TMO) timeout("b_valid");
    check("b_latency", 64'(cyc - last_cyc), 64'(1 + WR_LAT));
    @(posedge clk_i);
    @(negedge clk_i);
    check("aw_ready_after_b", aw_ready_o, 1);
    check("w_ready_after_b", w_ready_o, 1);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk_i);
    check("rst_ar_ready", ar_ready_o, 1);
    check("rst_aw_ready", aw_ready_o, 1);
    check("rst_w_ready", w_ready_o, 1);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_b_valid", b_valid_o, 0);
    check("rst_r_data", r_data_o, 0);
    check("rst_r_resp", r_resp_o, OKAY);
    check("rst_b_resp", b_resp_o, OKAY);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    write_tx(32'h8000_0000, 32'h0102_0304, 4'hF, OKAY, 0);
    write_tx(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, OKAY, 0);
    read_tx (32'h8000_0010, 32'hDEAD_BEEF, OKAY);
    write_tx(32'h8000_0010, 32'h1122_3344, 4'b0101, OKAY, 3);
    read_tx (32'h8000_0010, 32'hDE22_BE44, OKAY);
    read_tx (32'h8000_0013, 32'hDE22_BE44, OKAY);

    read_tx (32'h0000_0000, 32'h0, DECERR);
    write_tx(32'h9000_0000, 32'hAAAA_AAAA, 4'hF, DECERR, 0);
    read_tx (32'h8000_0000, 32'h0102_0304, OKAY);
    write_tx(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, OKAY, 0);
    read_tx (32'h8000_0FFC, 32'hCAFE_F00D, OKAY);
    read_tx (32'h8000_1000, 32'h0, DECERR);
    read_tx (32'h7FFF_FFFC, 32'h0, DECERR);

    // Stalled R channel keeps the response stable.
    r_ready_i = 1'b0;
    r_q.push_back({OKAY, 32'hDE22_BE44});
    @(posedge clk_i); #1;
    ar_valid_i = 1'b1;
    ar_addr_i  = 32'h8000_0010;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    t = 0;
    while (!r_valid_o && t < TMO) begin @(negedge clk_i); t++; end
    if (t >= TMO) timeout("stall_r_valid");
    for (int i = 0; i < 10; i++) begin
      check("stall_r_valid", r_valid_o, 1);
      check("stall_r_data", r_data_o, 32'hDE22_BE44);
      check("stall_ar_ready", ar_ready_o, 0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    r_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("stall_ar_ready_after", ar_ready_o, 1);

    // Reset pulse while the read is waiting.
    @(posedge clk_i); #1;
    ar_valid_i = 1'b1;
    ar_addr_i  = 32'h8000_0010;
    @(negedge clk_i);
    check("rrst_ar_ready", ar_ready_o, 1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rrst_r_valid_now", r_valid_o, 0);
    check("rrst_ar_ready_now", ar_ready_o, 1);
    repeat (2) begin
      @(negedge clk_i);
      check("rrst_r_valid_hold", r_valid_o, 0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check("rrst_r_valid_after", r_valid_o, 0);
    end
    read_tx(32'h8000_0010, 32'hDE22_BE44, OKAY);
    read_tx(32'h8000_0000, 32'h0102_0304, OKAY);

    repeat (2) @(negedge clk_i);
    check("r_q_drained", 64'(r_q.size()), 0);
    check("b_q_drained", 64'(b_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
